// File: rtl/afu_csr_arbiter_if.sv
// CSR bus bundle for afu_csr_arbiter: two requesting masters (m0 host MMIO,
// m1 management/DMA descriptors) plus the shared CSR slave port.
// The arbiter takes the 'slave' view: it serves m0/m1 and drives the s_* command.
interface afu_csr_arbiter_if #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 3
);
  logic                  m0_read;
  logic                  m0_write;
  logic [ADDR_WIDTH-1:0] m0_address;
  logic [DATA_WIDTH-1:0] m0_writedata;
  logic                  m0_waitrequest;
  logic [DATA_WIDTH-1:0] m0_readdata;
  logic                  m0_readdatavalid;

  logic                  m1_read;
  logic                  m1_write;
  logic [ADDR_WIDTH-1:0] m1_address;
  logic [DATA_WIDTH-1:0] m1_writedata;
  logic                  m1_waitrequest;
  logic [DATA_WIDTH-1:0] m1_readdata;
  logic                  m1_readdatavalid;

  logic                  s_read;
  logic                  s_write;
  logic [ADDR_WIDTH-1:0] s_address;
  logic [DATA_WIDTH-1:0] s_writedata;
  logic [DATA_WIDTH-1:0] s_readdata;

  logic                  proto_err;

  modport slave (
    input  m0_read, m0_write, m0_address, m0_writedata,
    input  m1_read, m1_write, m1_address, m1_writedata,
    input  s_readdata,
    output m0_waitrequest, m0_readdata, m0_readdatavalid,
    output m1_waitrequest, m1_readdata, m1_readdatavalid,
    output s_read, s_write, s_address, s_writedata,
    output proto_err
  );

  modport master (
    output m0_read, m0_write, m0_address, m0_writedata,
    output m1_read, m1_write, m1_address, m1_writedata,
    output s_readdata,
    input  m0_waitrequest, m0_readdata, m0_readdatavalid,
    input  m1_waitrequest, m1_readdata, m1_readdatavalid,
    input  s_read, s_write, s_address, s_writedata,
    input  proto_err
  );
endinterface

// File: rtl/afu_csr_arbiter.sv
// Two-master round-robin arbiter onto the AFU 64-bit CSR slave.
// One command accepted per cycle, registered onto s_*; reads are tagged with
// the issuing master so fixed-latency s_readdata is steered back correctly.
module afu_csr_arbiter #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 3,
  parameter int RD_LATENCY = 1
) (
  input logic               clk,
  input logic               reset,
  afu_csr_arbiter_if.slave  bus
);

  logic                  req0, req1;
  logic                  grant0, grant1;
  logic                  last_grant_q, last_grant_d;

  logic                  win_read, win_write;
  logic [ADDR_WIDTH-1:0] win_address;
  logic [DATA_WIDTH-1:0] win_writedata;

  logic                  s_read_q, s_read_d;
  logic                  s_write_q, s_write_d;
  logic [ADDR_WIDTH-1:0] s_address_q, s_address_d;
  logic [DATA_WIDTH-1:0] s_writedata_q, s_writedata_d;
  logic                  proto_err_q, proto_err_d;

  // Tag pipeline: stage 0 lines up with s_read, stage RD_LATENCY with s_readdata.
  logic [RD_LATENCY:0]   tag_v_q, tag_v_d;
  logic [RD_LATENCY:0]   tag_id_q, tag_id_d;
  logic                  head_v, head_id;
  logic                  rsp0, rsp1;

  assign req0 = bus.m0_read | bus.m0_write;
  assign req1 = bus.m1_read | bus.m1_write;

  // Round-robin grant: on contention the master that did not win last time goes.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (!reset) begin
      if (req0 && req1) begin
        grant0 = last_grant_q;
        grant1 = ~last_grant_q;
      end else begin
        grant0 = req0;
        grant1 = req1;
      end
    end
  end

  // Winner mux and next-state for the registered slave command and tags.
  always_comb begin
    win_read      = grant0 ? bus.m0_read      : bus.m1_read;
    win_write     = grant0 ? bus.m0_write     : bus.m1_write;
    win_address   = grant0 ? bus.m0_address   : bus.m1_address;
    win_writedata = grant0 ? bus.m0_writedata : bus.m1_writedata;

    last_grant_d  = last_grant_q;
    s_read_d      = 1'b0;
    s_write_d     = 1'b0;
    s_address_d   = s_address_q;
    s_writedata_d = s_writedata_q;
    proto_err_d   = proto_err_q;

    if (grant0 || grant1) begin
      last_grant_d  = grant1;
      // A simultaneous read+write goes out as a write; the read is dropped.
      s_read_d      = win_read & ~win_write;
      s_write_d     = win_write;
      s_address_d   = win_address;
      s_writedata_d = win_writedata;
      if (win_read && win_write) begin
        proto_err_d = 1'b1;
      end
    end

    tag_v_d  = {tag_v_q[RD_LATENCY-1:0], s_read_d};
    tag_id_d = {tag_id_q[RD_LATENCY-1:0], grant1};
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant_q  <= 1'b1;
      s_read_q      <= 1'b0;
      s_write_q     <= 1'b0;
      s_address_q   <= '0;
      s_writedata_q <= '0;
      proto_err_q   <= 1'b0;
      tag_v_q       <= '0;
      tag_id_q      <= '0;
    end else begin
      last_grant_q  <= last_grant_d;
      s_read_q      <= s_read_d;
      s_write_q     <= s_write_d;
      s_address_q   <= s_address_d;
      s_writedata_q <= s_writedata_d;
      proto_err_q   <= proto_err_d;
      tag_v_q       <= tag_v_d;
      tag_id_q      <= tag_id_d;
    end
  end

  assign head_v  = tag_v_q[RD_LATENCY];
  assign head_id = tag_id_q[RD_LATENCY];
  assign rsp0    = head_v & ~head_id;
  assign rsp1    = head_v & head_id;

  assign bus.m0_waitrequest   = ~grant0;
  assign bus.m1_waitrequest   = ~grant1;
  assign bus.m0_readdatavalid = rsp0;
  assign bus.m1_readdatavalid = rsp1;
  assign bus.m0_readdata      = rsp0 ? bus.s_readdata : '0;
  assign bus.m1_readdata      = rsp1 ? bus.s_readdata : '0;

  assign bus.s_read      = s_read_q;
  assign bus.s_write     = s_write_q;
  assign bus.s_address   = s_address_q;
  assign bus.s_writedata = s_writedata_q;
  assign bus.proto_err   = proto_err_q;

endmodule

// File: doc/afu_csr_arbiter.md
# afu_csr_arbiter

Two-master round-robin arbiter sharing the AFU's 64-bit CSR Avalon-MM slave (AFU header, AFU ID, scratch) between the host MMIO path (master 0) and an internal management/DMA-descriptor master (master 1). It accepts at most one command per cycle and registers the winning command onto the slave port. It tags each issued read so the slave's fixed-latency readdata is returned to the correct master with a readdatavalid strobe.

## Interface
- DATA_WIDTH, 64, data width of all masters and the slave
- ADDR_WIDTH, 3, word address width (8 x 64-bit CSRs)
- RD_LATENCY, 1, slave read latency in cycles from s_read sampled to s_readdata valid; legal 1..4
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- m0_read, m1_read  in  1  read request, held until accepted
- m0_write, m1_write  in  1  write request, held until accepted
- m0_address, m1_address  in  ADDR_WIDTH  word address
- m0_writedata, m1_writedata  in  DATA_WIDTH  write data
- m0_waitrequest, m1_waitrequest  out  1  high = command not accepted this cycle
- m0_readdata, m1_readdata  out  DATA_WIDTH  read return data
- m0_readdatavalid, m1_readdatavalid  out  1  one-cycle strobe per accepted read
- s_read, s_write  out  1  registered command to CSR slave
- s_address  out  ADDR_WIDTH  registered address
- s_writedata  out  DATA_WIDTH  registered write data
- s_readdata  in  DATA_WIDTH  slave read data
- proto_err  out  1  sticky: a master asserted read and write together

## Operation
- reqN = mN_read | mN_write. Grant is computed combinationally each cycle from reqN and the last_grant register.
- Only one requester: it is granted. Both requesting: the master not equal to last_grant is granted. Neither requesting: no grant, and last_grant holds.
- last_grant updates to the granted index on every grant. Its reset value is 1, so m0 wins the first contention.
- mN_waitrequest = ~grantN. It is high when idle, when losing arbitration, and during reset.
- On a grant, the winner's command is registered into s_*. s_read/s_write are high for exactly one cycle per accepted command and low on cycles with no grant.
- If mN_read & mN_write are both high when granted: the command is issued as a write only, the read is discarded (no readdatavalid), and proto_err is set. proto_err clears only on reset.
- Read tag pipeline: a RD_LATENCY+1 stage shift register of {valid, master_id}. Its head is aligned with s_readdata.
- At the head: mN_readdatavalid = valid & (id==N), and mN_readdata = s_readdata when valid & (id==N), else 0.
- Writes produce no response.
- Reset (at any time): s_read, s_write, all readdatavalid, the tag pipeline and proto_err clear to 0; s_address and s_writedata clear to 0; last_grant resets to 1. Reads in flight at reset are dropped and never return.

## Timing
- Accept cycle t: reqN & grantN, with mN_waitrequest low in t.
- s_read/s_write/s_address/s_writedata are valid in t+1.
- Read return: mN_readdatavalid and mN_readdata are valid in cycle t+1+RD_LATENCY (t+2 at the default).
- Throughput is one command per cycle. Back-to-back reads from alternating or identical masters return in issue order, one per cycle, with no bubbles.
- Under continuous contention, grants alternate m0, m1, m0, ... Worst-case wait for any requester is 1 cycle.
- No combinational path from s_readdata to any waitrequest. The only combinational input-to-output paths are reqN to waitrequest, and s_readdata to mN_readdata.

## Test plan
- Reset, then idle: all outputs 0 except both waitrequest = 1 during reset. After reset, idle masters see waitrequest = 1 and s_read = s_write = 0.
- m0 reads address 2 alone at cycle t, with the slave returning 64'h331D_B30C_9885_41EA. Expect: s_read and s_address = 2 in t+1; m0_readdatavalid with that value in t+2; m1_readdatavalid stays 0.
- Both masters hold reads (m0 addr 1, m1 addr 0) for 4 cycles. Expect:
  - grant order m0, m1, m0, m1;
  - s_address sequence 1, 0, 1, 0;
  - readdatavalid strobes alternating m0/m1 on consecutive cycles starting t+2.
- m1 writes 64'hDEAD_BEEF to address 5, then m0 reads address 5 in the next cycle. Expect s_write then s_read on consecutive cycles, and m0 receives 64'hDEAD_BEEF.
- m0 asserts read and write together to address 5. Expect: one s_write, no s_read, no readdatavalid, proto_err = 1 until the next reset.
- RD_LATENCY = 3: issue a read, then assert reset 2 cycles after s_read. Expect no readdatavalid on any cycle after reset. The next read after reset returns at accept + 4.
